// File: rtl/sd_cmd_pkg.sv
// SD command engine shared definitions.
// States, response encodings and frame constants.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_TAIL
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_R1   = 2'd1,
        RESP_R3   = 2'd2,
        RESP_RSV  = 2'd3
    } resp_t;

    localparam int         FRAME_BITS = 48;
    localparam int         NCC_CYCLES = 8;
    localparam logic [6:0] CRC7_POLY  = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first.
// Shared between the transmit and receive phases.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    // Shift one data bit into the remainder; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD card command-line sequencer: clocking, command
// serialisation with CRC7 and response capture.
module sd_cmd_engine
    import sd_cmd_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter int NCR_MAX = 64
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        crc_err,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        sd_clk,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int NW = $clog2(NCR_MAX + 1);
    localparam int CW = (NW > 6) ? NW : 6;

    state_t        state, state_n;
    resp_t         rt;
    logic [DW-1:0] div;
    logic          tick, rise, fall;
    logic [CW-1:0] cnt;
    logic [47:0]   tx_sr;
    logic [44:0]   rx_sr;
    logic [45:0]   rx_full;
    logic          tx_bit;
    logic [2:0]    crc_sel;
    logic          crc_clr, crc_en, crc_din;
    logic [6:0]    crc;

    assign tick    = (state != S_IDLE) && (div == DW'(CLK_DIV - 1));
    assign rise    = tick & ~sd_clk;
    assign fall    = tick & sd_clk;
    assign rx_full = {rx_sr, sd_cmd_in};
    assign crc_sel = 3'(cnt - CW'(1));

    // Bits 47..8 come from the shift register, 7..1 from the CRC.
    assign tx_bit = (cnt >= CW'(8)) ? tx_sr[47] :
                    (cnt != '0)     ? crc[crc_sel] : 1'b1;

    assign busy       = (state != S_IDLE);
    assign sd_cmd_oe  = (state == S_SEND);
    assign sd_cmd_out = (state == S_SEND) ? tx_bit : 1'b1;

    sd_crc7 u_crc (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= S_IDLE;
        else                state <= state_n;
    end

    // Next state and CRC control.
    always_comb begin
        state_n = state;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SEND;
                    crc_clr = 1'b1;
                end
            end
            S_SEND: begin
                if (fall && cnt >= CW'(8)) begin
                    crc_en  = 1'b1;
                    crc_din = tx_sr[47];
                end
                if (rise && cnt == '0) begin
                    state_n = (rt == RESP_NONE) ? S_TAIL : S_WAIT;
                    crc_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (rise) begin
                    if (!sd_cmd_in)
                        state_n = S_RECV;
                    else if (cnt == CW'(NCR_MAX - 1))
                        state_n = S_TAIL;
                end
            end
            S_RECV: begin
                if (rise && cnt >= CW'(8)) begin
                    crc_en  = 1'b1;
                    crc_din = sd_cmd_in;
                end
                if (rise && cnt == '0)
                    state_n = S_TAIL;
            end
            S_TAIL: begin
                if (fall && cnt == CW'(NCC_CYCLES))
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Clock divider; sd_clk parks low whenever the engine is idle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div    <= '0;
            sd_clk <= 1'b0;
        end else if (state == S_IDLE || state_n == S_IDLE) begin
            div    <= '0;
            sd_clk <= 1'b0;
        end else if (tick) begin
            div    <= '0;
            sd_clk <= ~sd_clk;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Bit counting, shift registers and result flags.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt        <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rt         <= RESP_NONE;
            done       <= 1'b0;
            timeout    <= 1'b0;
            crc_err    <= 1'b0;
            resp_index <= '0;
            resp_arg   <= '0;
        end else begin
            done <= (state == S_TAIL) && (state_n == S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_sr   <= {2'b01, cmd_index, cmd_arg, 8'hFF};
                        rt      <= resp_t'((resp_type == 2'd3) ? 2'd1 : resp_type);
                        cnt     <= CW'(FRAME_BITS - 1);
                        timeout <= 1'b0;
                        crc_err <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (fall && cnt != '0) begin
                        tx_sr <= {tx_sr[46:0], 1'b1};
                        cnt   <= cnt - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        if (!sd_cmd_in) begin
                            cnt <= CW'(FRAME_BITS - 2);
                        end else if (cnt == CW'(NCR_MAX - 1)) begin
                            timeout <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_RECV: begin
                    if (rise) begin
                        rx_sr <= rx_full[44:0];
                        if (cnt == '0) begin
                            resp_index <= rx_full[45:40];
                            resp_arg   <= rx_full[39:8];
                            crc_err    <= ((rt != RESP_R3) && (rx_full[7:1] != crc))
                                          || !rx_full[0];
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                S_TAIL: begin
                    if (rise) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
